// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial sequence detector with selectable overlap,
// registered match pulse and saturating match counter.
//
// state | meaning
// UNCFG | no valid configuration held; stream ignored
// RUN   | configuration held; stream shifted and compared
module seq_detect_prog #(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = 4,
   parameter int CNT_W   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
   input  logic               in_valid,
   input  logic               x,
   input  logic               cnt_clr,
   output logic               match,
   output logic [CNT_W-1:0]   match_count,
   output logic               armed,
   output logic               cfg_err
);

   localparam int FILL_W = $clog2(MAX_LEN + 1);

   typedef enum logic {UNCFG, RUN} state_t;

   state_t               state_q, state_d;
   logic [MAX_LEN-1:0]   hist_q, hist_d, hist_n;
   logic [MAX_LEN-1:0]   pat_q, pat_d, mask;
   logic [FILL_W-1:0]    fill_q, fill_d, fill_n;
   logic [LEN_W-1:0]     len_q, len_d;
   logic                 ovl_q, ovl_d;
   logic                 match_q, match_d;
   logic                 err_q, err_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 cfg_legal;
   logic                 hit;

   assign cfg_legal = (cfg_len != '0) && (int'(cfg_len) <= MAX_LEN);
   assign hist_n    = {hist_q[MAX_LEN-2:0], x};
   assign fill_n    = (fill_q == FILL_W'(MAX_LEN)) ? fill_q : fill_q + FILL_W'(1);

   // Only the low len_q bits of history and pattern take part in the compare.
   always_comb begin
      mask = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         mask[i] = (i < int'(len_q));
      end
   end

   always_comb begin
      state_d = state_q;
      hist_d  = hist_q;
      fill_d  = fill_q;
      pat_d   = pat_q;
      len_d   = len_q;
      ovl_d   = ovl_q;
      err_d   = err_q;
      hit     = 1'b0;

      if (cfg_load && cfg_legal) begin
         state_d = RUN;
         pat_d   = cfg_pattern;
         len_d   = cfg_len;
         ovl_d   = cfg_overlap;
         hist_d  = '0;
         fill_d  = '0;
      end else begin
         if (cfg_load) begin
            err_d = 1'b1;
         end
         if (state_q == RUN && in_valid) begin
            hit = (int'(fill_n) >= int'(len_q)) && ((hist_n & mask) == (pat_q & mask));
            if (hit && !ovl_q) begin
               hist_d = '0;
               fill_d = '0;
            end else begin
               hist_d = hist_n;
               fill_d = fill_n;
            end
         end
      end

      match_d = hit;

      cnt_d = cnt_q;
      if (cnt_clr) begin
         cnt_d = hit ? CNT_W'(1) : '0;
      end else if (hit && cnt_q != '1) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= UNCFG;
         hist_q  <= '0;
         fill_q  <= '0;
         pat_q   <= '0;
         len_q   <= '0;
         ovl_q   <= 1'b0;
         match_q <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         pat_q   <= pat_d;
         len_q   <= len_d;
         ovl_q   <= ovl_d;
         match_q <= match_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign match       = match_q;
   assign match_count = cnt_q;
   assign armed       = (state_q == RUN);
   assign cfg_err     = err_q;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Bench for seq_detect_prog: directed scenarios plus randomized stream,
// checked against a bit-queue reference model.
module tb_seq_detect_prog;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       cfg_load = 1'b0;
   logic [7:0] cfg_pattern = '0;
   logic [3:0] cfg_len = '0;
   logic       cfg_overlap = 1'b0;
   logic       in_valid = 1'b0;
   logic       x = 1'b0;
   logic       cnt_clr = 1'b0;

   logic       match, armed, cfg_err;
   logic [7:0] match_count;
   logic       match_s, armed_s, cfg_err_s;
   logic [1:0] match_count_s;

   int compared = 0;
   int mismatched = 0;

   // Reference model state
   bit       mdl_cfgd;
   bit [7:0] mdl_pat;
   int       mdl_len;
   bit       mdl_ovl;
   bit       mdl_err;
   bit       mdl_q[$];
   int       mdl_cnt8, mdl_cnt2;
   bit       exp_match;

   always #5 clk = ~clk;

   seq_detect_prog #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid), .x(x),
      .cnt_clr(cnt_clr), .match(match), .match_count(match_count),
      .armed(armed), .cfg_err(cfg_err)
   );

   seq_detect_prog #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2)) dut_s (
      .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid), .x(x),
      .cnt_clr(cnt_clr), .match(match_s), .match_count(match_count_s),
      .armed(armed_s), .cfg_err(cfg_err_s)
   );

   task automatic model_clear();
      mdl_cfgd = 0; mdl_pat = '0; mdl_len = 0; mdl_ovl = 0; mdl_err = 0;
      mdl_q.delete(); mdl_cnt8 = 0; mdl_cnt2 = 0; exp_match = 0;
   endtask

   // Drives one cycle of inputs and advances the model; returns at posedge+1.
   task automatic drive(input bit ld, input logic [7:0] pat, input logic [3:0] len,
                        input bit ovl, input bit v, input bit xb, input bit clr);
      bit h;
      h = 0;
      @(negedge clk);
      cfg_load = ld; cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
      in_valid = v; x = xb; cnt_clr = clr;
      if (ld && len >= 1 && len <= 8) begin
         mdl_cfgd = 1; mdl_pat = pat; mdl_len = int'(len); mdl_ovl = ovl;
         mdl_q.delete();
      end else begin
         if (ld) mdl_err = 1;
         if (mdl_cfgd && v) begin
            mdl_q.push_back(xb);
            if (mdl_q.size() > 8) void'(mdl_q.pop_front());
            if (mdl_q.size() >= mdl_len) begin
               h = 1;
               for (int i = 0; i < mdl_len; i++)
                  if (mdl_q[mdl_q.size() - mdl_len + i] != mdl_pat[mdl_len - 1 - i]) h = 0;
            end
            if (h && !mdl_ovl) mdl_q.delete();
         end
      end
      if (clr) begin
         mdl_cnt8 = h; mdl_cnt2 = h;
      end else if (h) begin
         if (mdl_cnt8 < 255) mdl_cnt8++;
         if (mdl_cnt2 < 3) mdl_cnt2++;
      end
      exp_match = h;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(0, 8'h00, 4'd0, 0, 0, 0, 0);
   endtask

   task automatic test_reset();
      bit s[4] = '{1, 1, 0, 0};
      rst = 1'b1;
      model_clear();
      #1;
      compared++;
      if (match !== 1'b0 || match_count !== 8'd0 || armed !== 1'b0 || cfg_err !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_vals: match=%0b count=%0d armed=%0b err=%0b required all 0",
                  match, match_count, armed, cfg_err);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(0, 8'h0c, 4'd4, 0, 1, s[i], 0);
         compared++;
         if (match !== 1'b0 || armed !== 1'b0 || match_count !== 8'd0) begin
            mismatched++;
            $display("FAIL uncfg_ignore[%0d]: match=%0b armed=%0b count=%0d required 0,0,0",
                     i, match, armed, match_count);
         end
      end
   endtask

   task automatic test_fixed_1100();
      bit s[8] = '{1, 1, 0, 0, 1, 1, 0, 0};
      drive(1, 8'b1100, 4'd4, 0, 0, 0, 0);
      compared++;
      if (armed !== 1'b1) begin
         mismatched++;
         $display("FAIL armed_after_load: got %0b required 1", armed);
      end
      for (int i = 0; i < 8; i++) begin
         drive(0, 8'h00, 4'd0, 0, 1, s[i], 0);
         compared++;
         if (match !== exp_match || match !== (i == 3 || i == 7)) begin
            mismatched++;
            $display("FAIL match_1100[bit %0d]: got %0b required %0b", i + 1, match, exp_match);
         end
      end
      compared++;
      if (match_count !== 8'd2) begin
         mismatched++;
         $display("FAIL count_1100: got %0d required 2", match_count);
      end
   endtask

   task automatic test_overlap();
      bit s[5] = '{1, 0, 1, 0, 1};
      for (int ov = 1; ov >= 0; ov--) begin
         drive(1, 8'b101, 4'd3, ov[0], 0, 0, 1);
         for (int i = 0; i < 5; i++) begin
            drive(0, 8'h00, 4'd0, 0, 1, s[i], 0);
            compared++;
            if (match !== exp_match || match !== (i == 2 || (ov == 1 && i == 4))) begin
               mismatched++;
               $display("FAIL match_101_ovl%0d[bit %0d]: got %0b required %0b",
                        ov, i + 1, match, exp_match);
            end
         end
         compared++;
         if (match_count !== ((ov == 1) ? 8'd2 : 8'd1)) begin
            mismatched++;
            $display("FAIL count_101_ovl%0d: got %0d required %0d", ov, match_count, mdl_cnt8);
         end
      end
   endtask

   task automatic test_cfg_err();
      bit s[3] = '{1, 0, 1};
      drive(1, 8'hff, 4'd0, 1, 0, 0, 0);
      compared++;
      if (cfg_err !== 1'b1 || armed !== 1'b1) begin
         mismatched++;
         $display("FAIL cfg_err_len0: err=%0b armed=%0b required 1,1", cfg_err, armed);
      end
      drive(1, 8'hff, 4'd9, 1, 0, 0, 0);
      compared++;
      if (cfg_err !== 1'b1 || armed !== 1'b1) begin
         mismatched++;
         $display("FAIL cfg_err_len9: err=%0b armed=%0b required 1,1", cfg_err, armed);
      end
      for (int i = 0; i < 3; i++) begin
         drive(0, 8'h00, 4'd0, 0, 1, s[i], 0);
         compared++;
         if (match !== exp_match || match !== (i == 2)) begin
            mismatched++;
            $display("FAIL keep_old_cfg[bit %0d]: got %0b required %0b", i + 1, match, exp_match);
         end
      end
      drive(1, 8'b1, 4'd1, 1, 0, 0, 0);
      compared++;
      if (cfg_err !== 1'b1) begin
         mismatched++;
         $display("FAIL cfg_err_sticky: got %0b required 1", cfg_err);
      end
   endtask

   task automatic test_saturation();
      int req[5] = '{1, 2, 3, 3, 3};
      drive(1, 8'b1, 4'd1, 1, 0, 0, 1);
      for (int i = 0; i < 5; i++) begin
         drive(0, 8'h00, 4'd0, 0, 1, 1, 0);
         compared++;
         if (int'(match_count_s) !== req[i] || match_s !== 1'b1) begin
            mismatched++;
            $display("FAIL sat_count[%0d]: got %0d/%0b required %0d/1",
                     i, match_count_s, match_s, req[i]);
         end
      end
      drive(0, 8'h00, 4'd0, 0, 1, 1, 1);
      compared++;
      if (match_count_s !== 2'd1 || match_count !== 8'd1) begin
         mismatched++;
         $display("FAIL clr_with_hit: got %0d/%0d required 1/1", match_count_s, match_count);
      end
      drive(0, 8'h00, 4'd0, 0, 0, 0, 1);
      compared++;
      if (match_count_s !== 2'd0 || match_count !== 8'd0) begin
         mismatched++;
         $display("FAIL clr_alone: got %0d/%0d required 0/0", match_count_s, match_count);
      end
   endtask

   task automatic test_reload_abort();
      bit s[3] = '{1, 1, 0};
      drive(1, 8'b1100, 4'd4, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) drive(0, 8'h00, 4'd0, 0, 1, s[i], 0);
      drive(1, 8'b1100, 4'd4, 0, 1, 0, 0);
      compared++;
      if (match !== 1'b0) begin
         mismatched++;
         $display("FAIL reload_drop: got %0b required 0", match);
      end
      drive(0, 8'h00, 4'd0, 0, 1, 0, 0);
      compared++;
      if (match !== exp_match || match !== 1'b0 || match_count !== 8'd0) begin
         mismatched++;
         $display("FAIL reload_abort: match=%0b count=%0d required 0,0", match, match_count);
      end
   endtask

   task automatic test_reset_mid();
      bit s[4] = '{1, 1, 0, 0};
      for (int i = 0; i < 4; i++) drive(0, 8'h00, 4'd0, 0, 1, s[i], 0);
      compared++;
      if (match !== 1'b1) begin
         mismatched++;
         $display("FAIL pre_reset_match: got %0b required 1", match);
      end
      #2;
      rst = 1'b1;
      model_clear();
      #1;
      compared++;
      if (match !== 1'b0 || match_count !== 8'd0 || armed !== 1'b0) begin
         mismatched++;
         $display("FAIL async_reset: match=%0b count=%0d armed=%0b required 0,0,0",
                  match, match_count, armed);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(0, 8'h00, 4'd0, 0, 1, s[i], 0);
         compared++;
         if (match !== 1'b0 || armed !== 1'b0) begin
            mismatched++;
            $display("FAIL post_reset_uncfg[%0d]: match=%0b armed=%0b required 0,0",
                     i, match, armed);
         end
      end
   endtask

   task automatic test_random();
      bit ld, v, clr;
      logic [7:0] pat;
      logic [3:0] len;
      for (int n = 0; n < 1500; n++) begin
         ld  = ($urandom_range(0, 39) == 0) || (n == 0);
         pat = 8'($urandom());
         len = 4'($urandom_range(0, 9));
         if (n == 0) len = 4'd2;
         v   = ($urandom_range(0, 3) != 0);
         clr = ($urandom_range(0, 49) == 0);
         drive(ld, pat, len, 1'($urandom()), v, 1'($urandom()), clr);
         compared++;
         if (match !== exp_match || match_s !== exp_match || armed !== mdl_cfgd ||
             cfg_err !== mdl_err || int'(match_count) !== mdl_cnt8 ||
             int'(match_count_s) !== mdl_cnt2) begin
            mismatched++;
            $display("FAIL random[%0d]: match=%0b/%0b armed=%0b err=%0b cnt=%0d/%0d required %0b armed=%0b err=%0b cnt=%0d/%0d",
                     n, match, match_s, armed, cfg_err, match_count, match_count_s,
                     exp_match, mdl_cfgd, mdl_err, mdl_cnt8, mdl_cnt2);
         end
      end
   endtask

   initial begin
      model_clear();
      @(posedge clk);
      #1;
      test_reset();
      test_fixed_1100();
      test_overlap();
      test_cfg_err();
      test_saturation();
      test_reload_abort();
      test_reset_mid();
      test_random();
      idle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/seq_detect_prog.md
Name: seq_detect_prog

Overview:
- Runtime-programmable serial sequence detector; the generalised successor to the team's fixed-pattern Mealy detectors (e.g. "1100").
- Pattern and length (1..MAX_LEN) are loaded by configuration. Overlapping or non-overlapping matching is selectable.
- Provides a one-cycle registered match pulse and a saturating match counter.
- Sits on a bit-serial input stream qualified by in_valid; feeds the status/interrupt logic.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (2..32).
- LEN_W, 4, width of cfg_len; must satisfy 2^LEN_W > MAX_LEN.
- CNT_W, 8, width of match_count.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_load  in  1  load the configuration for one cycle.
- cfg_pattern  in  MAX_LEN  pattern; bit cfg_len-1 is the first bit received, bit 0 the last.
- cfg_len  in  LEN_W  pattern length; legal range 1..MAX_LEN.
- cfg_overlap  in  1  1 = overlapping matches allowed; 0 = history restarts after a match.
- in_valid  in  1  qualifies x.
- x  in  1  serial data bit.
- cnt_clr  in  1  synchronous clear of match_count.
- match  out  1  registered one-cycle pulse when a pattern completes.
- match_count  out  CNT_W  saturating count of matches.
- armed  out  1  high while a valid configuration is held (state RUN).
- cfg_err  out  1  sticky flag: an illegal cfg_len was loaded.

Behaviour:
- Reset (async):
  - State = UNCFG; hist = 0; fill = 0.
  - pat_r = 0, len_r = 0, ovl_r = 0.
  - match = 0, match_count = 0, armed = 0, cfg_err = 0.
- State machine:
  - Two states, UNCFG and RUN. armed = (state == RUN).
  - UNCFG: in_valid/x are ignored and match stays 0.
  - A legal cfg_load moves UNCFG to RUN, or stays in RUN with the new configuration.
  - An illegal cfg_load (cfg_len = 0 or > MAX_LEN) sets cfg_err. State and the stored configuration are unchanged; hist and fill are not touched.
  - cfg_err clears only on rst.
- Legal cfg_load:
  - Captures pat_r, len_r and ovl_r, and clears hist and fill.
  - It has priority over in_valid in the same cycle: that x is dropped and match = 0 next cycle.
  - Reloading in RUN aborts any partial match.
- RUN, in_valid = 1, edge k:
  - hist_n = {hist[MAX_LEN-2:0], x}.
  - fill_n = min(fill + 1, MAX_LEN).
  - hit = (fill_n >= len_r) && (hist_n[len_r-1:0] == pat_r[len_r-1:0]). Bits above len_r-1 are masked.
  - On hit, match = 1 from edge k until edge k+1. This is Mealy-registered timing: the pulse appears at the edge that samples the final bit, with zero added latency.
  - hit with ovl_r = 1: hist <= hist_n and fill <= fill_n.
  - hit with ovl_r = 0: hist <= 0 and fill <= 0.
  - No hit: hist <= hist_n, fill <= fill_n, match <= 0.
- RUN, in_valid = 0: hist and fill hold; match <= 0.
- Back-to-back matches: match stays high for consecutive cycles, one per completed pattern. Example: len 1, pattern 1, overlap, input 1,1 gives match high for 2 cycles.
- match_count:
  - Increments by 1 on each hit and saturates at 2^CNT_W-1.
  - cnt_clr and hit in the same cycle gives match_count = 1.
  - cnt_clr alone gives 0.
  - cnt_clr is honoured in any state.
- Width rules:
  - fill is wide enough to hold MAX_LEN.
  - The len_r mask is built as a MAX_LEN-bit vector; there is no out-of-range indexing.
- Reset mid-stream: all state is lost immediately. The block must be reconfigured before detection resumes.

Test Plan:
- Reset, then in_valid = 1 with x = 1,1,0,0 and no cfg_load -> match stays 0, armed = 0, match_count = 0.
- Load pattern 4'b1100, len 4, overlap 0; stream 1,1,0,0,1,1,0,0 -> match pulses on the edges sampling bits 4 and 8; match_count = 2.
- Load pattern 3'b101, len 3, overlap 1; stream 1,0,1,0,1 -> match on bits 3 and 5; count = 2. Repeat with overlap 0 -> match on bit 3 only; count = 1.
- Load with cfg_len = 0, then cfg_len = 9 (MAX_LEN = 8) -> cfg_err = 1, armed unchanged, previous pattern still detected; a following legal load keeps cfg_err = 1.
- CNT_W = 2, len 1, pattern 1; stream of five 1s -> count goes 1,2,3,3,3. cnt_clr coincident with the 6th hit -> count = 1.
- Mid-pattern after 1,1,0: cfg_load of the same pattern with in_valid = 1 -> that bit is dropped and a final 0 does not match. Separately, assert rst mid-pattern -> outputs 0 immediately and armed = 0.
